// File: rtl/led_pwm_breath_if.sv
// ---------------------------------------------------------------------------
// led_pwm_breath_if
// Groups the pattern/brightness inputs and LED/status outputs of
// led_pwm_breath. Clock and reset are kept as plain module ports.
//
// Signals:
//   i_led_en    [P_LED_NUMBER] per-lane enable from the blink driver
//   i_breath_en [1]            1 = breathing ramp, 0 = fixed duty
//   i_duty      [P_PWM_BITS]   fixed duty used when i_breath_en = 0
//   o_led       [P_LED_NUMBER] registered LED pin levels
//   o_duty      [P_PWM_BITS]   duty currently applied to the comparator
//   o_phase     [2]            breathing state (0 UP, 1 HOLD_HI, 2 DOWN, 3 HOLD_LO)
//
// Modports:
//   master - the block that drives the enables/duty and observes the LEDs
//   slave  - led_pwm_breath itself
//
// The inputs are level signals with no valid/ready handshake: every
// input is sampled on every rising clock edge, and every output is a
// register that is valid in every cycle after reset.
// ---------------------------------------------------------------------------
interface led_pwm_breath_if #(
    parameter int P_LED_NUMBER = 1,
    parameter int P_PWM_BITS   = 8
);
    logic [P_LED_NUMBER-1:0] i_led_en;
    logic                    i_breath_en;
    logic [P_PWM_BITS-1:0]   i_duty;
    logic [P_LED_NUMBER-1:0] o_led;
    logic [P_PWM_BITS-1:0]   o_duty;
    logic [1:0]              o_phase;

    modport master (
        output i_led_en, i_breath_en, i_duty,
        input  o_led, o_duty, o_phase
    );

    modport slave (
        input  i_led_en, i_breath_en, i_duty,
        output o_led, o_duty, o_phase
    );
endinterface

// File: rtl/led_pwm_breath.sv
// ---------------------------------------------------------------------------
// led_pwm_breath
// PWM brightness stage that sits between the LED blink driver and the
// board pins. Every lit lane is modulated with a PWM whose duty is either
// a fixed value or an automatic breathing ramp
// (UP -> HOLD_HI -> DOWN -> HOLD_LO -> UP ...).
// Everything runs on i_clk; the breathing ramp advances on a one-clock
// step tick rather than on a derived clock.
//
// Ports:
//   i_clk  - system clock
//   i_rst  - asynchronous reset, active low
//   bus    - led_pwm_breath_if.slave (i_led_en, i_breath_en, i_duty in;
//            o_led, o_duty, o_phase out)
//
// Parameters:
//   P_LED_NUMBER - number of LED lanes
//   P_PWM_BITS   - duty width B; PWM period is 2^B-1 clocks
//   P_STEP_CLKS  - clocks per breathing step tick
//   P_HOLD_STEPS - step ticks spent in each hold phase
//   P_LED_ON     - pin level of a lit LED (unlit = ~P_LED_ON)
//
// Optional build macro:
//   LED_PWM_GAMMA_EN - when defined, the comparator uses a gamma-corrected
//                      duty g = (o_duty*o_duty) >> B, except that full
//                      duty stays full. o_duty still reports the linear
//                      value.
// ---------------------------------------------------------------------------
module led_pwm_breath #(
    parameter int   P_LED_NUMBER = 1,
    parameter int   P_PWM_BITS   = 8,
    parameter int   P_STEP_CLKS  = 50000,
    parameter int   P_HOLD_STEPS = 100,
    parameter logic P_LED_ON     = 1'b1
) (
    input logic              i_clk,
    input logic              i_rst,
    led_pwm_breath_if.slave  bus
);

    localparam int C_STEP_W = (P_STEP_CLKS > 1) ? $clog2(P_STEP_CLKS) : 1;
    localparam int C_HOLD_W = (P_HOLD_STEPS > 1) ? $clog2(P_HOLD_STEPS) : 1;

    localparam logic [P_PWM_BITS-1:0]   C_DUTY_MAX  = {P_PWM_BITS{1'b1}};
    localparam logic [P_PWM_BITS-1:0]   C_PWM_TOP   = {{(P_PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [P_PWM_BITS-1:0]   C_DUTY_ONE  = {{(P_PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [C_STEP_W-1:0]     C_STEP_LAST = C_STEP_W'(P_STEP_CLKS - 1);
    localparam logic [C_HOLD_W-1:0]     C_HOLD_LAST = C_HOLD_W'(P_HOLD_STEPS - 1);
    localparam logic [P_LED_NUMBER-1:0] C_LED_OFF   = {P_LED_NUMBER{~P_LED_ON}};

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_HOLD_HI = 2'd1,
        ST_DOWN    = 2'd2,
        ST_HOLD_LO = 2'd3
    } phase_t;

    logic [P_PWM_BITS-1:0]   r_pwm_cnt;
    logic [C_STEP_W-1:0]     r_step_cnt;
    logic                    w_tick;

    phase_t                  r_phase,    w_phase_nx;
    logic [P_PWM_BITS-1:0]   r_bduty,    w_bduty_nx;
    logic [C_HOLD_W-1:0]     r_hold_cnt, w_hold_nx;

    logic [P_PWM_BITS-1:0]   w_src_duty;
    logic [P_PWM_BITS-1:0]   r_duty;
    logic [P_PWM_BITS-1:0]   w_cmp_duty;
    logic                    w_pwm_on;
    logic [P_LED_NUMBER-1:0] w_lit;
    logic [P_LED_NUMBER-1:0] r_led;

    // PWM counter: 0 .. 2^B-2, so duty 2^B-1 compares as always on.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pwm_cnt <= '0;
        end else if (r_pwm_cnt == C_PWM_TOP) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + C_DUTY_ONE;
        end
    end

    // Step counter runs in both modes; the tick is its terminal count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_step_cnt <= '0;
        end else if (r_step_cnt == C_STEP_LAST) begin
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

    assign w_tick = (r_step_cnt == C_STEP_LAST);

    // Breathing FSM: state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_phase    <= ST_UP;
            r_bduty    <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_phase    <= w_phase_nx;
            r_bduty    <= w_bduty_nx;
            r_hold_cnt <= w_hold_nx;
        end
    end

    // Breathing FSM: next state. The ramp saturates at both ends and the
    // phase changes on the same tick that reaches the end value.
    always_comb begin
        w_phase_nx = r_phase;
        w_bduty_nx = r_bduty;
        w_hold_nx  = r_hold_cnt;
        if (!bus.i_breath_en) begin
            // Parked at the start of the ramp so enabling restarts from 0.
            w_phase_nx = ST_UP;
            w_bduty_nx = '0;
            w_hold_nx  = '0;
        end else if (w_tick) begin
            case (r_phase)
                ST_UP: begin
                    if (r_bduty >= C_PWM_TOP) begin
                        w_bduty_nx = C_DUTY_MAX;
                        w_phase_nx = ST_HOLD_HI;
                        w_hold_nx  = '0;
                    end else begin
                        w_bduty_nx = r_bduty + C_DUTY_ONE;
                    end
                end
                ST_HOLD_HI: begin
                    if (r_hold_cnt >= C_HOLD_LAST) begin
                        w_phase_nx = ST_DOWN;
                        w_hold_nx  = '0;
                    end else begin
                        w_hold_nx  = r_hold_cnt + 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (r_bduty <= C_DUTY_ONE) begin
                        w_bduty_nx = '0;
                        w_phase_nx = ST_HOLD_LO;
                        w_hold_nx  = '0;
                    end else begin
                        w_bduty_nx = r_bduty - C_DUTY_ONE;
                    end
                end
                ST_HOLD_LO: begin
                    if (r_hold_cnt >= C_HOLD_LAST) begin
                        w_phase_nx = ST_UP;
                        w_hold_nx  = '0;
                    end else begin
                        w_hold_nx  = r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    w_phase_nx = ST_UP;
                    w_bduty_nx = '0;
                    w_hold_nx  = '0;
                end
            endcase
        end
    end

    assign w_src_duty = bus.i_breath_en ? r_bduty : bus.i_duty;

    // Duty is only taken at period start, so a period never mixes two
    // duties. A tick on the same edge is seen next period (r_bduty here is
    // still the pre-tick value).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_duty <= '0;
        end else if (r_pwm_cnt == '0) begin
            r_duty <= w_src_duty;
        end
    end

`ifdef LED_PWM_GAMMA_EN
    logic [2*P_PWM_BITS-1:0] w_sq;
    logic [P_PWM_BITS-1:0]   w_gamma;
    logic [P_PWM_BITS-1:0]   r_gduty;

    assign w_sq    = {{P_PWM_BITS{1'b0}}, w_src_duty} * {{P_PWM_BITS{1'b0}}, w_src_duty};
    // The squared curve would top out just below full scale; pin full duty
    // to full scale so maximum brightness stays always-on.
    assign w_gamma = (w_src_duty == C_DUTY_MAX) ? C_DUTY_MAX
                                                : w_sq[2*P_PWM_BITS-1:P_PWM_BITS];

    // Latched on the same edge as r_duty so the pair never disagrees.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_gduty <= '0;
        end else if (r_pwm_cnt == '0) begin
            r_gduty <= w_gamma;
        end
    end

    assign w_cmp_duty = r_gduty;
`else
    assign w_cmp_duty = r_duty;
`endif

    assign w_pwm_on = (r_pwm_cnt < w_cmp_duty);
    assign w_lit    = bus.i_led_en & {P_LED_NUMBER{w_pwm_on}};

    // XOR with the off pattern maps lit/unlit onto the board's pin polarity.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_led <= C_LED_OFF;
        end else begin
            r_led <= w_lit ^ C_LED_OFF;
        end
    end

    assign bus.o_led   = r_led;
    assign bus.o_duty  = r_duty;
    assign bus.o_phase = r_phase;

endmodule

// File: tb/tb_led_pwm_breath.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_breath
// Self-checking bench for led_pwm_breath with B=4 (period 15), 4 clocks per
// step tick, 2 hold ticks, active-high LED, one lane. A reference model
// derives duty and phase from the number of ticks since breathing was
// enabled and the PWM position from the clock count since reset, and is
// compared with the DUT after every clock. Table vectors, hand-written
// corner sequences and a random phase drive the inputs.
// Define LED_PWM_GAMMA_EN for both the bench and the RTL to test gamma.
// ---------------------------------------------------------------------------
module tb_led_pwm_breath;

    localparam int B     = 4;
    localparam int M     = 15;   // 2^B-1: period length and full duty
    localparam int STEP  = 4;
    localparam int HOLD  = 2;
    localparam int CYC   = 2 * M + 2 * HOLD;
`ifdef LED_PWM_GAMMA_EN
    localparam bit GAMMA = 1'b1;
`else
    localparam bit GAMMA = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    led_pwm_breath_if #(.P_LED_NUMBER(1), .P_PWM_BITS(B)) bus ();

    led_pwm_breath #(
        .P_LED_NUMBER (1),
        .P_PWM_BITS   (B),
        .P_STEP_CLKS  (STEP),
        .P_HOLD_STEPS (HOLD),
        .P_LED_ON     (1'b1)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_n;     // clocks since reset release
    int m_k;     // step ticks since breathing was (re)enabled
    int m_duty;  // latched duty
    int m_cmp;   // duty actually compared (gamma or linear)
    int m_led;

    function automatic int bduty_of(int k);
        int kk;
        kk = k % CYC;
        if (kk < M)                 return kk;
        else if (kk < M + HOLD)     return M;
        else if (kk < 2 * M + HOLD) return M - (kk - M - HOLD);
        else                        return 0;
    endfunction

    function automatic int phase_of(int k);
        int kk;
        kk = k % CYC;
        if (kk < M)                 return 0;
        else if (kk < M + HOLD)     return 1;
        else if (kk < 2 * M + HOLD) return 2;
        else                        return 3;
    endfunction

    function automatic int gam(int d);
        if (d == M) return M;
        return (d * d) / (M + 1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_n    = 0;
        m_k    = 0;
        m_duty = 0;
        m_cmp  = 0;
        m_led  = 0;
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare all outputs 1 ns later.
    task automatic step();
        int p;
        int src;
        int nl;
        @(posedge i_clk);
        p   = m_n % M;
        src = bus.i_breath_en ? bduty_of(m_k) : int'(bus.i_duty);
        nl  = (bus.i_led_en[0] && (p < m_cmp)) ? 1 : 0;
        if (p == 0) begin
            m_duty = src;
            m_cmp  = GAMMA ? gam(src) : src;
        end
        if (!bus.i_breath_en)              m_k = 0;
        else if ((m_n % STEP) == STEP - 1) m_k++;
        m_n++;
        m_led = nl;
        #1;
        check("led",   32'(bus.o_led),   m_led);
        check("duty",  32'(bus.o_duty),  m_duty);
        check("phase", 32'(bus.o_phase), phase_of(m_k));
    endtask

    // Asynchronous reset in the middle of a clock; outputs must clear at once.
    task automatic do_reset();
        #2;
        i_rst = 1'b0;
        #1;
        check("rst_led",   32'(bus.o_led),   0);
        check("rst_duty",  32'(bus.o_duty),  0);
        check("rst_phase", 32'(bus.o_phase), 0);
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    typedef struct {
        int duty;
        bit en;
        int exp_hi;
    } vec_t;

    vec_t vt[7];

    initial begin
        int hi;
        i_rst           = 1'b0;
        bus.i_led_en    = 1'b1;
        bus.i_breath_en = 1'b0;
        bus.i_duty      = '0;
        model_reset();

        // Table: fixed duty -> high clocks per 15-clock window
        vt[0] = '{duty: 5,  en: 1'b1, exp_hi: GAMMA ? 1  : 5};
        vt[1] = '{duty: 0,  en: 1'b1, exp_hi: 0};
        vt[2] = '{duty: 15, en: 1'b1, exp_hi: 15};
        vt[3] = '{duty: 8,  en: 1'b1, exp_hi: GAMMA ? 4  : 8};
        vt[4] = '{duty: 5,  en: 1'b0, exp_hi: 0};
        vt[5] = '{duty: 1,  en: 1'b1, exp_hi: GAMMA ? 0  : 1};
        vt[6] = '{duty: 14, en: 1'b1, exp_hi: GAMMA ? 12 : 14};

        #12;
        check("init_led",   32'(bus.o_led),   0);
        check("init_duty",  32'(bus.o_duty),  0);
        check("init_phase", 32'(bus.o_phase), 0);
        @(negedge i_clk);
        i_rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            bus.i_duty   = B'(vt[i].duty);
            bus.i_led_en = vt[i].en;
            repeat (30) step();
            hi = 0;
            repeat (M) begin
                step();
                hi += int'(bus.o_led[0]);
            end
            check("hi_cnt", hi, vt[i].exp_hi);
        end

        // Mid-period duty change 5 -> 10 at r_pwm_cnt = 3
        bus.i_led_en = 1'b1;
        bus.i_duty   = 4'd5;
        repeat (30) step();
        for (int c = 0; c < M && (m_n % M) != 3; c++) step();
        check("mid_align", m_n % M, 3);
        bus.i_duty = 4'd10;
        for (int c = 0; c < M; c++) begin
            step();
            if ((m_n % M) == 1) begin
                check("mid_new", 32'(bus.o_duty), 10);
                break;
            end
            check("mid_old", 32'(bus.o_duty), 5);
        end
        repeat (M) step();

        // Breathing from reset, with lane gating at full duty
        bus.i_breath_en = 1'b1;
        do_reset();
        for (int c = 1; c <= 136; c++) begin
            step();
            if (c == 60)  check("br_hold_hi", 32'(bus.o_phase), 1);
            if (c == 61)  check("br_full",    32'(bus.o_duty), 15);
            if (c == 68)  check("br_down",    32'(bus.o_phase), 2);
            if (c == 128) check("br_hold_lo", 32'(bus.o_phase), 3);
            if (c == 136) check("br_up",      32'(bus.o_phase), 0);
            if (c >= 63 && c <= 66) check("gate_off", 32'(bus.o_led), 0);
            if (c == 67)  check("gate_on",    32'(bus.o_led), 1);
            if (c == 62)  bus.i_led_en = 1'b0;
            if (c == 66)  bus.i_led_en = 1'b1;
        end

        // Reset mid-ramp at o_duty = 7, then ramp restarts from 0
        do_reset();
        repeat (32) step();
        check("pre_rst_duty",  32'(bus.o_duty),  7);
        check("pre_rst_phase", 32'(bus.o_phase), 0);
        do_reset();
        repeat (32) step();
        check("ramp_restart", 32'(bus.o_duty), 7);

        // Random stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.i_led_en = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 19) == 0) bus.i_duty = B'($urandom_range(0, M));
            if ($urandom_range(0, 299) == 0) bus.i_breath_en = ~bus.i_breath_en;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
